// File: rtl/vga_timing_encoder.sv
// 640x480@60 VGA raster generator with shader-latency-matched sync/blank
// and TinyTapeout VGA PMOD pin packing on a fully registered uo_out.
module vga_timing_encoder #(
  parameter int LATENCY   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] rgb_in,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       pix_valid,
  output logic       frame_start,
  output logic [7:0] frame_count,
  output logic [7:0] uo_out
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic vis;
  } tap_t;

  localparam tap_t IDLE = '{hs_n: 1'b1, vs_n: 1'b1, vis: 1'b0};

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [7:0] fc_q, fc_d;
  logic [7:0] uo_q, uo_d;
  logic       x_wrap, y_wrap;
  tap_t       tup, tap;
  logic [5:0] col;

  always_comb begin
    x_wrap = (x_q == H_LAST);
    y_wrap = (y_q == V_LAST);
    x_d    = x_wrap ? 10'd0 : x_q + 10'd1;
    y_d    = y_q;
    fc_d   = fc_q;
    if (x_wrap) begin
      y_d = y_wrap ? 10'd0 : y_q + 10'd1;
      if (y_wrap) fc_d = fc_q + 8'd1;
    end
  end

  always_comb begin
    tup.vis  = (x_q < H_VIS) && (y_q < V_VIS);
    tup.hs_n = !((x_q >= HS_BEG) && (x_q <= HS_END));
    tup.vs_n = !((y_q >= VS_BEG) && (y_q <= VS_END));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= '0;
      y_q  <= '0;
      fc_q <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      fc_q <= fc_d;
    end
  end

  // Sync/blank ride alongside the shader pipeline to meet rgb_in.
  if (LATENCY == 0) begin : g_nodly
    assign tap = tup;
  end else begin : g_dly
    tap_t dly_q [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < LATENCY; i++) dly_q[i] <= IDLE;
      end else begin
        dly_q[0] <= tup;
        for (int i = 1; i < LATENCY; i++) dly_q[i] <= dly_q[i-1];
      end
    end

    assign tap = dly_q[LATENCY-1];
  end

  always_comb begin
    col  = tap.vis ? rgb_in : 6'd0;
    uo_d = {tap.hs_n, col[0], col[2], col[4],
            tap.vs_n, col[1], col[3], col[5]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) uo_q <= 8'h88;
    else        uo_q <= uo_d;
  end

  assign pix_x       = x_q;
  assign pix_y       = y_q;
  assign pix_valid   = tup.vis;
  assign frame_start = (x_q == 10'd0) && (y_q == 10'd0);
  assign frame_count = fc_q;
  assign uo_out      = uo_q;

endmodule

// File: tb/tb_vga_timing_encoder.sv
// Scoreboard bench: one full-size LATENCY=2 raster plus three tiny
// rasters (LATENCY 0/8/2) to reach frame wrap within the cycle budget.
module tb_vga_timing_encoder;

  logic clk = 1'b0;
  logic rst_n;
  int   mode;
  int   total = 0;
  int   bad   = 0;
  int   cyc_now;

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [5:0] colour(input int m, input int x);
    logic [31:0] xv;
    xv = x;
    case (m)
      0:       return xv[5:0];
      1:       return 6'h3f;
      2:       return 6'h20;
      3:       return 6'h01;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic logic [7:0] pins(input bit hs, input bit vs,
                                      input logic [5:0] c);
    return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int  L    = (g == 0) ? 2 : (g == 1) ? 0 : (g == 2) ? 8 : 2;
    localparam bit  TINY = (g != 0);
    localparam int  HV   = TINY ? 4 : 640;
    localparam int  HF   = TINY ? 1 : 16;
    localparam int  HS   = TINY ? 2 : 96;
    localparam int  HB   = TINY ? 1 : 48;
    localparam int  VV   = TINY ? 3 : 480;
    localparam int  VF   = TINY ? 1 : 10;
    localparam int  VS   = TINY ? 1 : 2;
    localparam int  VB   = TINY ? 1 : 33;
    localparam int  HT   = HV + HF + HS + HB;
    localparam int  VT   = VV + VF + VS + VB;

    logic [5:0] rgb = '0;
    logic [9:0] px, py;
    logic       pv, fs;
    logic [7:0] fc, uo;

    vga_timing_encoder #(
      .LATENCY(L),
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rgb_in(rgb),
      .pix_x(px),
      .pix_y(py),
      .pix_valid(pv),
      .frame_start(fs),
      .frame_count(fc),
      .uo_out(uo)
    );

    initial begin
      int mx, my, mf;
      bit hs, vs, vis;
      logic [5:0] c;
      logic [7:0] e;
      logic [7:0] expq [$];
      logic [5:0] colq [$];
      mx = 0; my = 0; mf = 0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          mx = 0; my = 0; mf = 0;
          expq.delete();
          colq.delete();
          for (int i = 0; i <= L; i++) expq.push_back(8'h88);
          chk($sformatf("rst_uo%0d", g), uo, 8'h88);
          chk($sformatf("rst_x%0d", g), px, 0);
          chk($sformatf("rst_y%0d", g), py, 0);
          chk($sformatf("rst_fc%0d", g), fc, 0);
          chk($sformatf("rst_fs%0d", g), fs, 1);
          chk($sformatf("rst_pv%0d", g), pv, 1);
        end else begin
          chk($sformatf("x%0d", g), px, mx);
          chk($sformatf("y%0d", g), py, my);
          chk($sformatf("pv%0d", g), pv, (mx < HV && my < VV));
          chk($sformatf("fs%0d", g), fs, (mx == 0 && my == 0));
          chk($sformatf("fc%0d", g), fc, mf);
        end
        hs  = !(mx >= HV + HF && mx < HV + HF + HS);
        vs  = !(my >= VV + VF && my < VV + VF + VS);
        vis = (mx < HV && my < VV);
        c   = colour(mode, mx);
        colq.push_back(c);
        if (colq.size() == L + 1) rgb = colq.pop_front();
        else                      rgb = '0;
        expq.push_back(pins(hs, vs, vis ? c : 6'd0));
        e = expq.pop_front();
        if (rst_n) chk($sformatf("uo%0d", g), uo, e);
        mx++;
        if (mx == HT) begin
          mx = 0;
          my++;
          if (my == VT) begin
            my = 0;
            mf = (mf + 1) % 256;
          end
        end
      end
    end
  end

  task automatic goto(input int k);
    repeat (k - cyc_now) @(negedge clk);
    cyc_now = k;
  endtask

  task automatic set_mode(input int m);
    @(posedge clk);
    #1 mode = m;
  endtask

  initial begin
    rst_n = 1'b0;
    mode  = 1;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b1;
    cyc_now = 0;

    goto(2);   chk("pre_col", g_dut[0].uo, 8'h88);
    goto(3);   chk("col_on", g_dut[0].uo, 8'hff);
    goto(642); chk("col_last", g_dut[0].uo, 8'hff);
    goto(643); chk("col_off", g_dut[0].uo, 8'h88);
    goto(658); chk("hs_pre", g_dut[0].uo, 8'h88);
    goto(659); chk("hs_beg", g_dut[0].uo, 8'h08);
    goto(754); chk("hs_end", g_dut[0].uo, 8'h08);
    goto(755); chk("hs_post", g_dut[0].uo, 8'h88);

    goto(900);  set_mode(2);
    goto(1100); chk("pin_r1", g_dut[0].uo, 8'h89);
    goto(1150); set_mode(3);
    goto(1300); chk("pin_b0", g_dut[0].uo, 8'hc8);
    goto(1458); chk("hs2_pre", g_dut[0].uo[7], 1'b1);
    goto(1459); chk("hs2_beg", g_dut[0].uo[7], 1'b0);
    goto(1500); set_mode(0);
    goto(6000);

    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_uo0", g_dut[0].uo, 8'h88);
    chk("async_uo8", g_dut[2].uo, 8'h88);
    chk("async_x0", g_dut[0].px, 0);
    chk("async_fc", g_dut[3].fc, 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    cyc_now = 0;
    mode = 4;

    goto(658);   chk("re_hs_pre", g_dut[0].uo[7], 1'b1);
    goto(659);   chk("re_hs_beg", g_dut[0].uo[7], 1'b0);
    goto(12400); chk("wrap_fc3", g_dut[3].fc, 2);
    chk("wrap_fc1", g_dut[1].fc, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_encoder.md
Name: vga_timing_encoder

Overview:
- Generates the 640x480@60 VGA raster (800x525 total, 25 MHz pixel clock) and provides pixel coordinates to a shader pipeline.
- Delays sync and blanking by the shader's pipeline depth so they stay aligned with the returned colour.
- Packs 2-bit RGB plus both syncs into the 8-bit TinyTapeout output pin order consumed by the board-level VGA PMOD.
- Sits between the shader core and the top-level uo_out pins.

Parameters:
LATENCY, 2, shader pipeline depth in cycles from pix_x/pix_y to matching rgb_in; legal range 0..8
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch
H_SYNC, 96, horizontal sync width
H_BACK, 48, horizontal back porch
V_VISIBLE, 480, visible lines
V_FRONT, 10, vertical front porch
V_SYNC, 2, vertical sync width
V_BACK, 33, vertical back porch

Ports:
clk  input  1  pixel clock
rst_n  input  1  asynchronous active-low reset
rgb_in  input  6  shader colour {r1,r0,g1,g0,b1,b0}, sampled LATENCY cycles after its coordinate
pix_x  output  10  current horizontal counter, 0..799
pix_y  output  10  current vertical counter, 0..524
pix_valid  output  1  counter is inside the visible region
frame_start  output  1  counter is at (0,0)
frame_count  output  8  completed-frame counter, wraps
uo_out  output  8  registered pins: [7]=hsync_n, [6]=b0, [5]=g0, [4]=r0, [3]=vsync_n, [2]=b1, [1]=g1, [0]=r1

Behaviour:
- Reset: clock is clk; reset is rst_n, asynchronous and active-low. All registers clear immediately on rst_n low:
  - x, y, frame_count = 0.
  - Every delay-line stage holds the idle tuple (hsync_n=1, vsync_n=1, vis=0).
  - uo_out = 8'h88.
- Outputs during reset: pix_x=0, pix_y=0, pix_valid=1, frame_start=1. These follow the counters combinationally.
- Counters:
  - x increments every cycle and wraps 799->0.
  - On the x wrap, y increments; y wraps 524->0.
  - On the simultaneous wrap (799,524)->(0,0), frame_count increments and wraps 255->0.
- Combinational, from the current counter values:
  - pix_valid = (x<640 && y<480).
  - frame_start = (x==0 && y==0).
  - hs_n = !(656<=x<=751).
  - vs_n = !(490<=y<=491). Vsync is whole-line aligned and toggles at x=0.
- Delay line: the tuple (hs_n, vs_n, pix_valid) passes through LATENCY register stages. For LATENCY=0 it is used directly with no stages.
- Output register, updated every clk edge, fed from the delayed tuple:
  - uo_out[7] = hs_n, uo_out[3] = vs_n.
  - Colour bits = rgb_in when the delayed vis=1, else 0.
- Latency: uo_out at cycle t+LATENCY+1 reflects the counter value at cycle t. Cycle 0 is the first cycle after rst_n deasserts, with counter (0,0).
- Blanking overrides rgb_in completely; no colour leaks into porches or sync.
- Reset mid-frame:
  - Counters, delay line and uo_out return to their reset values within the same cycle.
  - The raster restarts at (0,0) on release.
  - frame_count resets to 0.
- The output has no combinational path from rgb_in or the counters to uo_out; it is fully registered.

Test Plan:
- Reset values, LATENCY=2: hold rst_n=0 and toggle clk -> uo_out=8'h88, pix_x=0, pix_y=0, frame_count=0, frame_start=1. Drive rst_n low asynchronously between edges -> uo_out becomes 8'h88 without a clock edge.
- Horizontal timing, LATENCY=2, line 0: uo_out[7] is low exactly on cycles 659..754 (96 cycles) and high elsewhere. Line period is 800 cycles; the next falling edge of uo_out[7] is at cycle 1459.
- Vertical timing: uo_out[3] is low for exactly 1600 consecutive cycles, starting at cycle 490*800+3 = 392003. Period is 420000 cycles. frame_count=1 once the counter reaches (0,0) at cycle 420000.
- Colour gating and pin map:
  - rgb_in=6'b111111 constant -> uo_out[6:4] and uo_out[2:0] are all 1 on cycles 3..642 of line 0 and 0 on cycles 643..802.
  - rgb_in=6'b100000 -> only uo_out[0]=1.
  - rgb_in=6'b000001 -> only uo_out[6]=1.
- Alignment: rgb_in = {pix_x[5:0]} registered through a LATENCY-deep shift register, run with LATENCY=0, 2 and 8 -> the decoded colour at output cycle k+LATENCY+1 equals k[5:0] for every visible k.
- Reset mid-frame: assert rst_n low at counter (300,200) for 3 cycles and release -> uo_out=8'h88 during reset. Counters resume from (0,0), frame_count=0, and the first hsync low again occurs at cycle 656+LATENCY+1.
